// File: rtl/sseg_scan_decoder.sv
// Snoops a multiplexed active-low seven-segment bus and rebuilds a coherent
// four-digit frame (hex nibble, dp and illegal-pattern flag per digit).
module sseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] hex_out,
  output logic [3:0]  dp_out,
  output logic [3:0]  bad_out,
  output logic        frame_strobe,
  output logic        scan_lost
);

  // state       | meaning
  // ST_IDLE     | no valid digit select; stability count cleared
  // ST_TRACK    | counting consecutive identical {s_an, s_sseg} samples
  // ST_CAPTURED | current sample already captured; wait for it to change
  typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_CAPTURED} state_t;

  localparam logic [3:0]  STABLE_CMP  = 4'(STABLE_CYCLES);
  localparam logic [15:0] TIMEOUT_CMP = 16'(TIMEOUT_CYCLES);

  logic [3:0]  an_meta, s_an;
  logic [7:0]  sseg_meta, s_sseg;

  state_t      state_q, state_d;
  logic [11:0] held_q, held_d;
  logic [3:0]  stab_q, stab_d;
  logic [3:0]  run;
  logic        capture;

  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic [3:0]  dec_val;
  logic        dec_bad;

  logic [15:0] slot_hex;
  logic [3:0]  slot_dp, slot_bad;
  logic [3:0]  seen_q, seen_d;

  logic [15:0] to_q, to_d;
  logic [1:0]  inv_q, inv_d;
  logic        lost_d, lost_rise, flush;

  // Idle bus is all ones, so the synchronizers reset to that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_meta   <= '1;
      s_an      <= '1;
      sseg_meta <= '1;
      s_sseg    <= '1;
    end else begin
      an_meta   <= an;
      s_an      <= an_meta;
      sseg_meta <= sseg;
      s_sseg    <= sseg_meta;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 2'd0;
    case (s_an)
      4'b1110: begin sel_valid = 1'b1; sel_idx = 2'd0; end
      4'b1101: begin sel_valid = 1'b1; sel_idx = 2'd1; end
      4'b1011: begin sel_valid = 1'b1; sel_idx = 2'd2; end
      4'b0111: begin sel_valid = 1'b1; sel_idx = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    dec_val = 4'hF;
    dec_bad = 1'b0;
    case (s_sseg[6:0])
      7'h01: dec_val = 4'h0;
      7'h4F: dec_val = 4'h1;
      7'h12: dec_val = 4'h2;
      7'h06: dec_val = 4'h3;
      7'h4C: dec_val = 4'h4;
      7'h24: dec_val = 4'h5;
      7'h20: dec_val = 4'h6;
      7'h0F: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h04: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h60: dec_val = 4'hB;
      7'h31: dec_val = 4'hC;
      7'h42: dec_val = 4'hD;
      7'h30: dec_val = 4'hE;
      7'h38: dec_val = 4'hF;
      default: dec_bad = 1'b1;
    endcase
  end

  // run = length of the current identical-sample streak including this cycle
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    stab_d  = stab_q;
    capture = 1'b0;
    run     = 4'd1;
    if (state_q == ST_TRACK && {s_an, s_sseg} == held_q)
      run = (stab_q == 4'hF) ? 4'hF : stab_q + 4'd1;
    if (!sel_valid) begin
      state_d = ST_IDLE;
      stab_d  = 4'd0;
    end else if (state_q == ST_CAPTURED && {s_an, s_sseg} == held_q) begin
      state_d = ST_CAPTURED;
    end else begin
      held_d = {s_an, s_sseg};
      stab_d = run;
      if (run == STABLE_CMP) begin
        capture = 1'b1;
        state_d = ST_CAPTURED;
      end else begin
        state_d = ST_TRACK;
      end
    end
  end

  always_comb begin
    to_d  = capture ? 16'd0 : (to_q == TIMEOUT_CMP) ? to_q : to_q + 16'd1;
    inv_d = sel_valid ? 2'd0 : (inv_q == 2'd2) ? 2'd2 : inv_q + 2'd1;
    lost_d    = (to_d == TIMEOUT_CMP) || (inv_d == 2'd2);
    lost_rise = lost_d && !scan_lost;
    flush     = (seen_q == 4'hF) && !lost_rise;
    if (lost_rise) begin
      seen_d = 4'h0;
    end else begin
      seen_d = (seen_q == 4'hF) ? 4'h0 : seen_q;
      if (capture) seen_d[sel_idx] = 1'b1;
    end
  end

  assign scan_lost = (to_q == TIMEOUT_CMP) || (inv_q == 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      held_q       <= '1;
      stab_q       <= 4'd0;
      slot_hex     <= 16'h0;
      slot_dp      <= 4'h0;
      slot_bad     <= 4'h0;
      seen_q       <= 4'h0;
      to_q         <= 16'd0;
      inv_q        <= 2'd0;
      hex_out      <= 16'h0;
      dp_out       <= 4'h0;
      bad_out      <= 4'h0;
      frame_strobe <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      stab_q  <= stab_d;
      seen_q  <= seen_d;
      to_q    <= to_d;
      inv_q   <= inv_d;
      if (capture) begin
        slot_hex[{sel_idx, 2'b00} +: 4] <= dec_val;
        slot_dp[sel_idx]                <= s_sseg[7];
        slot_bad[sel_idx]               <= dec_bad;
      end
      frame_strobe <= flush;
      if (flush) begin
        hex_out <= slot_hex;
        dp_out  <= slot_dp;
        bad_out <= slot_bad;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: emulates the 4-cycle-per-digit
// multiplexer and checks frames, bad codes, timeout, glitches and reset.
module tb_sseg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic [15:0] hex_out;
  logic [3:0]  dp_out;
  logic [3:0]  bad_out;
  logic        frame_strobe;
  logic        scan_lost;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe = -1;
  int strobe_gap = 0;
  int s0;

  always #5 clk = ~clk;

  sseg_scan_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .an           (an),
    .sseg         (sseg),
    .hex_out      (hex_out),
    .dp_out       (dp_out),
    .bad_out      (bad_out),
    .frame_strobe (frame_strobe),
    .scan_lost    (scan_lost)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_strobe) begin
      if (last_strobe >= 0) strobe_gap <= cyc - last_strobe;
      last_strobe <= cyc;
      strobe_cnt  <= strobe_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
      4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
      4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
      4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
    endcase
  endfunction

  task automatic drive_raw(input logic [3:0] a, input logic [7:0] s, input int n);
    an   = a;
    sseg = s;
    tick(n);
  endtask

  task automatic drive(input int i, input logic [3:0] v, input logic dp, input int n);
    logic [3:0] sel;
    sel = 4'b0001;
    drive_raw(~(sel << i), {dp, seg_of(v)}, n);
  endtask

  task automatic frame(input logic [15:0] hex, input logic [3:0] dp);
    for (int i = 0; i < 4; i++) drive(i, hex[i*4 +: 4], dp[i], 4);
  endtask

  initial begin
    logic [3:0] vv;
    reset = 1'b1;
    an    = 4'hF;
    sseg  = 8'hFF;
    tick(2);
    check("rst_hex", 32'(hex_out), 32'h0);
    check("rst_dp", 32'(dp_out), 32'h0);
    check("rst_bad", 32'(bad_out), 32'h0);
    check("rst_strobe", 32'(frame_strobe), 32'h0);
    check("rst_lost", 32'(scan_lost), 32'h0);
    reset = 1'b0;
    tick(3);

    // normal scanning: three frames, strobes 16 cycles apart
    s0 = strobe_cnt;
    repeat (3) frame(16'h5A07, 4'b1100);
    tick(4);
    check("main_hex", 32'(hex_out), 32'h5A07);
    check("main_dp", 32'(dp_out), 32'hC);
    check("main_bad", 32'(bad_out), 32'h0);
    check("main_lost", 32'(scan_lost), 32'h0);
    check("main_nstrobe", 32'(strobe_cnt - s0), 32'd3);
    check("main_gap", 32'(strobe_gap), 32'd16);

    // digit 2 carries an illegal pattern
    s0 = strobe_cnt;
    drive(0, 4'h4, 1'b1, 4);
    drive(1, 4'h3, 1'b0, 4);
    drive_raw(4'b1011, 8'h7F, 4);
    drive(3, 4'h1, 1'b0, 4);
    tick(4);
    check("bad_hex", 32'(hex_out), 32'h1F34);
    check("bad_dp", 32'(dp_out), 32'h1);
    check("bad_bad", 32'(bad_out), 32'h4);
    check("bad_nstrobe", 32'(strobe_cnt - s0), 32'd1);

    // all 16 legal codes through digit 0
    for (int v = 0; v < 16; v++) begin
      vv = 4'(v);
      frame({4'hC, 4'hB, 4'h3, vv}, 4'b0000);
      tick(4);
      check("sweep_hex", 32'(hex_out), 32'({4'hC, 4'hB, 4'h3, vv}));
      check("sweep_bad", 32'(bad_out), 32'h0);
    end

    // freeze on digit 2 after a partial frame
    s0 = strobe_cnt;
    drive(0, 4'h9, 1'b0, 4);
    drive(1, 4'h8, 1'b0, 4);
    drive(2, 4'h6, 1'b0, 1028);
    check("freeze_lost_1023", 32'(scan_lost), 32'h0);
    tick(1);
    check("freeze_lost_1024", 32'(scan_lost), 32'h1);
    tick(71);
    check("freeze_lost_hold", 32'(scan_lost), 32'h1);
    check("freeze_nostrobe", 32'(strobe_cnt - s0), 32'd0);

    // resume starting at digit 3: partial pre-freeze frame must not survive
    drive(3, 4'h5, 1'b1, 4);
    check("resume_lost_pre", 32'(scan_lost), 32'h1);
    tick(1);
    check("resume_lost_post", 32'(scan_lost), 32'h0);
    drive(0, 4'h7, 1'b0, 4);
    drive(1, 4'h0, 1'b0, 4);
    check("resume_noearly", 32'(strobe_cnt - s0), 32'd0);
    drive(2, 4'hA, 1'b1, 4);
    tick(4);
    check("resume_nstrobe", 32'(strobe_cnt - s0), 32'd1);
    check("resume_hex", 32'(hex_out), 32'h5A07);
    check("resume_dp", 32'(dp_out), 32'hC);

    // digit 0 glitching every 2 cycles never captures
    s0 = strobe_cnt;
    for (int k = 0; k < 10; k++)
      drive_raw(4'b1110, {1'b0, seg_of((k % 2 == 1) ? 4'h2 : 4'h1)}, 2);
    drive(1, 4'h2, 1'b0, 4);
    drive(2, 4'h3, 1'b0, 4);
    drive(3, 4'h4, 1'b0, 4);
    tick(4);
    check("glitch_nostrobe", 32'(strobe_cnt - s0), 32'd0);
    check("glitch_hex_kept", 32'(hex_out), 32'h5A07);
    drive_raw(4'b1100, {1'b0, seg_of(4'h4)}, 2);
    drive_raw(4'b0111, {1'b0, seg_of(4'h4)}, 1);
    check("inv_lost_1", 32'(scan_lost), 32'h0);
    tick(1);
    check("inv_lost_2", 32'(scan_lost), 32'h1);
    tick(2);
    check("inv_lost_clear", 32'(scan_lost), 32'h0);

    // reset after two digits, then rescan
    drive(0, 4'h1, 1'b1, 4);
    drive(1, 4'h2, 1'b1, 4);
    reset = 1'b1;
    #1;
    check("mid_rst_hex", 32'(hex_out), 32'h0);
    check("mid_rst_dp", 32'(dp_out), 32'h0);
    check("mid_rst_bad", 32'(bad_out), 32'h0);
    check("mid_rst_strobe", 32'(frame_strobe), 32'h0);
    check("mid_rst_lost", 32'(scan_lost), 32'h0);
    tick(2);
    reset = 1'b0;
    s0 = strobe_cnt;
    drive(2, 4'h8, 1'b0, 4);
    drive(3, 4'hE, 1'b1, 4);
    drive(0, 4'hD, 1'b0, 4);
    check("post_rst_noearly", 32'(strobe_cnt - s0), 32'd0);
    drive(1, 4'h6, 1'b1, 4);
    tick(4);
    check("post_rst_nstrobe", 32'(strobe_cnt - s0), 32'd1);
    check("post_rst_hex", 32'(hex_out), 32'hE86D);
    check("post_rst_dp", 32'(dp_out), 32'hA);
    check("post_rst_bad", 32'(bad_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
